// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
//   Shares one synchronous block ROM (1-cycle read latency) between two
//   requesters. Each request is a start address plus a burst length
//   (words-1). Bursts are granted round-robin, run to completion, and
//   issue sequential addresses that wrap at the top of the ROM. Read data
//   comes back with a per-requester valid strobe and a last-word flag.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   reqN_valid/addr/len         burst request from requester N
//   reqN_ready                  request N accepted this cycle (valid&ready)
//   rom_en, rom_addr            ROM read port, owned exclusively here
//   rom_dout                    ROM registered read data
//   respN_valid                 resp_data belongs to requester N
//   resp_data                   returned word (straight from rom_dout)
//   resp_last                   final word of the current burst
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no burst in flight; combinational grant to one requester
// BURST  | rom_en high, one address per cycle until counter reaches 0
module rom_burst_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 20,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;    // 0: requester 0 wins a tie
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;      // words remaining after this one
  logic              resp0_q, resp1_q, last_q;
  logic              burst_final;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = S_BURST;
          owner_d = req1_ready;
          addr_d  = req1_ready ? req1_addr : req0_addr;
          cnt_d   = req1_ready ? req1_len  : req0_len;
          prio_d  = ~req1_ready;
        end
      end
      S_BURST: begin
        if (cnt_q == '0) begin
          // address is left untouched so rom_addr holds its last value
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rom_en     = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (req0_valid && (!req1_valid || !prio_q)) req0_ready = 1'b1;
      else if (req1_valid)                        req1_ready = 1'b1;
    end
    if (state_q == S_BURST) rom_en = 1'b1;
  end

  assign burst_final = (state_q == S_BURST) && (cnt_q == '0);

  // Response strobes track the ROM's one-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      resp0_q <= rom_en & ~owner_q;
      resp1_q <= rom_en &  owner_q;
      last_q  <= burst_final;
    end
  end

  assign rom_addr    = addr_q;
  assign resp0_valid = resp0_q;
  assign resp1_valid = resp1_q;
  assign resp_last   = last_q;
  assign resp_data   = rom_dout;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
module tb_rom_burst_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_addr, req1_addr;
  logic [3:0]  req0_len, req1_len;
  logic        req0_ready, req1_ready;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [19:0] rom_dout;
  logic        resp0_valid, resp1_valid, resp_last;
  logic [19:0] resp_data;

  int n_vec = 0;
  int n_err = 0;

  rom_burst_arbiter #(.ADDR_W(6), .DATA_W(20), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len),
    .req1_ready(req1_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_last(resp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: the four fixed words used by the directed cases, filler elsewhere
  function automatic logic [19:0] rom_val(input int a);
    logic [5:0] aa;
    aa = a[5:0];
    case (aa)
      6'd0:    return 20'h0200A;
      6'd1:    return 20'h00300;
      6'd62:   return 20'h08201;
      6'd63:   return 20'h0400D;
      default: return {aa, aa ^ 6'h2A, 8'hA5};
    endcase
  endfunction

  always @(posedge clk) if (rom_en) rom_dout <= rom_val(int'(rom_addr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int n, input logic v, input int a, input int l);
    if (n == 0) begin
      req0_valid = v; req0_addr = a[5:0]; req0_len = l[3:0];
    end else begin
      req1_valid = v; req1_addr = a[5:0]; req1_len = l[3:0];
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rvld(input int n);
    return (n == 0) ? resp0_valid : resp1_valid;
  endfunction

  // Present a request from 'own' (optionally with the other requester also
  // valid), then check every cycle of the grant, the burst and its responses.
  // Returns in the cycle carrying the final response word.
  task automatic burst(input int own, input int a, input int l,
                       input logic ov, input int oa, input int ol,
                       input logic keep, input logic churn);
    set_req(own, 1'b1, a, l);
    set_req(1 - own, ov, oa, ol);
    #1;
    chk("grant_own", rdy(own), 1);
    chk("grant_other", rdy(1 - own), 0);
    for (int c = 1; c <= l + 2; c++) begin
      tick();
      if (c == 1 && !keep) set_req(own, 1'b0, a, l);
      if (churn && c <= l + 1) set_req(own, keep, $urandom_range(0, 63), $urandom_range(0, 15));
      #1;
      chk("rom_en", rom_en, (c <= l + 1) ? 1 : 0);
      if (c <= l + 1) chk("rom_addr", rom_addr, (a + c - 1) % 64);
      chk("resp_own_valid", rvld(own), (c >= 2) ? 1 : 0);
      chk("resp_other_valid", rvld(1 - own), 0);
      if (c >= 2) begin
        chk("resp_data", resp_data, rom_val((a + c - 2) % 64));
        chk("resp_last", resp_last, (c == l + 2) ? 1 : 0);
      end
      if (c <= l + 1) begin
        chk("ready0_busy", req0_ready, 0);
        chk("ready1_busy", req1_ready, 0);
      end else begin
        chk("ready_own_after", rdy(own), (keep && !ov) ? 1 : 0);
        chk("ready_other_after", rdy(1 - own), ov ? 1 : 0);
      end
    end
  endtask

  task automatic idle_chk(input int hold_addr);
    tick();
    #1;
    chk("idle_rom_en", rom_en, 0);
    chk("idle_rom_addr", rom_addr, hold_addr);
    chk("idle_resp0", resp0_valid, 0);
    chk("idle_resp1", resp1_valid, 0);
    chk("idle_last", resp_last, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_req(0, 1'b1, 0, 0);
    set_req(1, 1'b1, 0, 0);
    tick();
    tick();
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_resp0", resp0_valid, 0);
    chk("rst_resp1", resp1_valid, 0);
    chk("rst_last", resp_last, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    rst = 1'b0;
    tick();

    // single read of address 0
    burst(0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("single_data", resp_data, 20'h0200A);
    idle_chk(0);

    // wrapping burst 62,63,0,1
    burst(1, 62, 3, 1'b0, 0, 0, 1'b0, 1'b0);
    idle_chk(1);

    // contention: grants alternate 0,1,0,1 from reset
    do_reset();
    burst(0, 10, 1, 1'b1, 20, 1, 1'b1, 1'b0);
    burst(1, 20, 1, 1'b1, 10, 1, 1'b1, 1'b0);
    burst(0, 10, 1, 1'b1, 20, 1, 1'b1, 1'b0);
    burst(1, 20, 1, 1'b1, 10, 1, 1'b1, 1'b0);
    set_req(0, 1'b0, 10, 1);
    set_req(1, 1'b0, 20, 1);
    idle_chk(21);

    // final response of req0 coincides with req1 acceptance
    burst(0, 5, 2, 1'b1, 30, 0, 1'b0, 1'b0);
    burst(1, 30, 0, 1'b0, 5, 2, 1'b0, 1'b0);
    idle_chk(30);

    // reset during the 3rd cycle of a 16-word burst
    set_req(0, 1'b1, 40, 15);
    #1;
    chk("long_grant", req0_ready, 1);
    tick();
    tick();
    tick();
    chk("long_addr_c3", rom_addr, 42);
    chk("long_en_c3", rom_en, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rom_en", rom_en, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_resp0", resp0_valid, 0);
    chk("mid_rst_resp1", resp1_valid, 0);
    chk("mid_rst_last", resp_last, 0);
    chk("mid_rst_ready0", req0_ready, 0);
    set_req(0, 1'b0, 40, 15);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_resp0", resp0_valid, 0);
    set_req(0, 1'b1, 7, 0);
    set_req(1, 1'b1, 1, 0);
    #1;
    chk("post_rst_prio0", req0_ready, 1);
    chk("post_rst_prio1", req1_ready, 0);
    burst(1, 1, 0, 1'b0, 7, 0, 1'b0, 1'b0);
    chk("post_rst_data", resp_data, 20'h00300);
    idle_chk(1);

    // request inputs churn during the owner's own burst
    burst(0, 50, 5, 1'b0, 0, 0, 1'b0, 1'b1);
    set_req(0, 1'b0, 0, 0);
    idle_chk(55);
    idle_chk(55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Shares one synchronous 64x20 block ROM (1-cycle read latency, read enable) between two requesters.
- Each request is a start address plus a burst length. Bursts are granted round-robin and are non-preemptive.
- The block generates sequential ROM addresses, with wrap from 63 to 0, and returns data with per-requester valid strobes and a last-word flag.
- It sits between client logic and the ROM instance; it owns the ROM's en/addr pins exclusively.

Parameters:
- ADDR_W, 6, ROM address width.
- DATA_W, 20, ROM data width.
- LEN_W, 4, burst length field width. Length is encoded as words-1, so 1..16 words.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req0_valid  in  1  requester 0 has a burst request.
- req0_addr  in  ADDR_W  requester 0 start address.
- req0_len  in  LEN_W  requester 0 burst length minus 1.
- req0_ready  out  1  requester 0 request accepted this cycle when valid&ready.
- req1_valid  in  1  requester 1 has a burst request.
- req1_addr  in  ADDR_W  requester 1 start address.
- req1_len  in  LEN_W  requester 1 burst length minus 1.
- req1_ready  out  1  requester 1 request accepted this cycle when valid&ready.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM read address.
- rom_dout  in  DATA_W  ROM registered read data, valid the cycle after rom_en.
- resp0_valid  out  1  resp_data belongs to requester 0 this cycle.
- resp1_valid  out  1  resp_data belongs to requester 1 this cycle.
- resp_data  out  DATA_W  returned word; driven directly from rom_dout.
- resp_last  out  1  final word of the current burst; qualified by resp0_valid or resp1_valid.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - rom_en=0, rom_addr=0.
  - resp0_valid=0, resp1_valid=0, resp_last=0.
  - Round-robin priority points to requester 0.
  - req0_ready and req1_ready are forced 0 while rst=1.
  - A burst in flight is abandoned and no further responses are issued for it.
- FSM states: IDLE, BURST.
- IDLE, grant selection (combinational ready):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester named by the priority pointer gets ready=1; the other gets 0.
  - At most one ready is high in any cycle.
  - Neither valid: both ready=0, stay in IDLE.
- Acceptance in cycle T (valid&ready):
  - Latch owner, addr and len.
  - Priority pointer moves to the other requester.
  - Go to BURST at T+1.
- BURST:
  - rom_en=1 for exactly len+1 consecutive cycles, T+1 through T+len+1.
  - rom_addr starts at the latched addr and increments by 1 each cycle, modulo 64 (63 wraps to 0).
  - A registered word counter tracks remaining words.
  - After the cycle carrying the final address, return to IDLE. The next acceptance is possible at T+len+2 at the earliest.
  - Both ready outputs stay 0 throughout BURST.
- Response pipeline:
  - respN_valid is a one-cycle-delayed copy of (rom_en & owner==N).
  - Word k of the burst appears at T+2+k.
  - resp_last is the delayed copy of "final address issued".
  - Responses have no backpressure; requesters must sink one word per cycle.
- Overlap of response and acceptance:
  - The final response (T+len+2) may coincide with a new acceptance in IDLE.
  - The new burst's first rom_en is at T+len+3, so response streams never overlap.
- Request inputs are sampled only at acceptance. Changes on addr/len/valid during BURST have no effect.
- A requester dropping valid before being granted is legal; no grant occurs.
- When rom_en=0, rom_addr holds its last value.
- resp_data equals rom_dout at all times; it is meaningful only when a resp valid is high.

Test Plan:
- Single read: reset, then req0 addr=0, len=0 accepted at T. Expect rom_en=1 with addr 0 at T+1; resp0_valid=1, resp_last=1, resp_data=0x0200A at T+2; resp1_valid never 1.
- Wrap burst: req1 addr=62, len=3. Expect rom_addr 62,63,0,1 on consecutive cycles; resp1 data 0x08201, 0x0400D, 0x0200A, 0x00300; resp_last only on the 4th word.
- Contention fairness: both valid continuously with len=1. Grants alternate 0,1,0,1 starting with 0 after reset. Each burst is 2 words, and a new rom_en starts every 3 cycles.
- Simultaneous response/accept: req0 len=2, with req1 valid throughout. req1_ready=1 exactly in the cycle req0's last word is returned; the first req1 rom_en is the following cycle; no cycle has both resp valids high.
- Reset mid-burst: assert rst during the 3rd cycle of a 16-word burst. rom_en, resp0_valid, resp1_valid and resp_last go 0 immediately. After release, IDLE with priority=0; a fresh req1 single read at addr 1 returns 0x00300.
- Input churn: change req0_addr/len during its own BURST. Issued addresses follow the latched values only; no extra words are returned.
